// File: rtl/cpu_rom_fetch_if.sv
// CPU-side read bus and SDRAM line-fetch bus for the CPU ROM fetch unit.
// The slave modport is the fetch unit; the master modport is the CPU/SDRAM side.
interface cpu_rom_fetch_if #(
    parameter int SDR_AW = 25
);
    logic              cpu_rd;
    logic              cpu_rom_memrq;
    logic [19:0]       rom_addr;
    logic              invalidate;
    logic [15:0]       cpu_dout;
    logic              cpu_ready;
    logic              busy;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_ack;
    logic [63:0]       sdr_data;

    modport slave (
        input  cpu_rd, cpu_rom_memrq, rom_addr, invalidate, sdr_ack, sdr_data,
        output cpu_dout, cpu_ready, busy, sdr_addr, sdr_req
    );

    modport master (
        output cpu_rd, cpu_rom_memrq, rom_addr, invalidate, sdr_ack, sdr_data,
        input  cpu_dout, cpu_ready, busy, sdr_addr, sdr_req
    );
endinterface

// File: rtl/cpu_rom_fetch.sv
// CPU program-word fetch from SDRAM through a single 64-bit line buffer.
// Hits answer one cycle after cpu_rd; misses answer one cycle after sdr_ack.
module cpu_rom_fetch #(
    parameter int                SDR_AW   = 25,
    parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
    input logic            clk,
    input logic            reset_n,
    cpu_rom_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t            state_q, state_d;
    logic              line_valid_q, line_valid_d;
    logic [16:0]       tag_q, tag_d;
    logic [63:0]       line_q, line_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [SDR_AW-1:0] addr_q, addr_d;

    logic [16:0]       req_tag;
    logic              start;
    logic              hit;

    function automatic logic [15:0] pick_word(input logic [63:0] line, input logic [1:0] sel);
        return line[16*sel +: 16];
    endfunction

    assign req_tag = bus.rom_addr[19:3];
    // A new bus cycle cannot start in the cycle the previous one completes.
    assign start   = bus.cpu_rd && bus.cpu_rom_memrq && !ready_q;
    assign hit     = line_valid_q && (req_tag == tag_q) && !bus.invalidate;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        line_d       = line_q;
        sel_d        = sel_q;
        dout_d       = dout_q;
        ready_d      = 1'b0;
        req_d        = req_q;
        busy_d       = busy_q;
        drop_d       = drop_q;
        addr_d       = addr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.invalidate) line_valid_d = 1'b0;
                if (start) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        dout_d  = pick_word(line_q, bus.rom_addr[2:1]);
                    end else begin
                        tag_d        = req_tag;
                        sel_d        = bus.rom_addr[2:1];
                        line_valid_d = 1'b0;
                        addr_d       = ROM_BASE + SDR_AW'({req_tag, 3'b000});
                        req_d        = 1'b1;
                        busy_d       = 1'b1;
                        drop_d       = 1'b0;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.invalidate) drop_d = 1'b1;
                if (bus.sdr_ack) begin
                    line_d       = bus.sdr_data;
                    line_valid_d = !(drop_q || bus.invalidate);
                    req_d        = 1'b0;
                    busy_d       = 1'b0;
                    ready_d      = 1'b1;
                    dout_d       = pick_word(bus.sdr_data, sel_q);
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (bus.invalidate) line_valid_d = 1'b0;
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            line_q       <= '0;
            sel_q        <= '0;
            dout_q       <= '0;
            ready_q      <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            ready_q      <= ready_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.cpu_dout  = dout_q;
    assign bus.cpu_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.sdr_addr  = addr_q;
    assign bus.sdr_req   = req_q;
endmodule

// File: tb/tb_cpu_rom_fetch.sv
// Directed bench for cpu_rom_fetch: two instances, ROM_BASE 0 and 0x0100000.
module tb_cpu_rom_fetch;
    logic clk = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cpu_rom_fetch_if #(.SDR_AW(25)) if0 ();
    cpu_rom_fetch_if #(.SDR_AW(25)) if1 ();

    cpu_rom_fetch #(.SDR_AW(25), .ROM_BASE(25'h0000000)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave)
    );
    cpu_rom_fetch #(.SDR_AW(25), .ROM_BASE(25'h0100000)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle cpu_rd pulse on instance 0; leaves the bus idle after the edge.
    task automatic rd0(input logic [19:0] addr, input logic memrq, input logic inv);
        if0.cpu_rd        = 1'b1;
        if0.cpu_rom_memrq = memrq;
        if0.rom_addr      = addr;
        if0.invalidate    = inv;
        tick();
        if0.cpu_rd        = 1'b0;
        if0.cpu_rom_memrq = 1'b0;
        if0.invalidate    = 1'b0;
    endtask

    task automatic ack0(input logic [63:0] data);
        if0.sdr_ack  = 1'b1;
        if0.sdr_data = data;
        tick();
        if0.sdr_ack  = 1'b0;
    endtask

    initial begin
        int bad;
        reset_n = 1'b0;
        if0.cpu_rd = 1'b0; if0.cpu_rom_memrq = 1'b0; if0.rom_addr = '0;
        if0.invalidate = 1'b0; if0.sdr_ack = 1'b0; if0.sdr_data = '0;
        if1.cpu_rd = 1'b0; if1.cpu_rom_memrq = 1'b0; if1.rom_addr = '0;
        if1.invalidate = 1'b0; if1.sdr_ack = 1'b0; if1.sdr_data = '0;
        tick();
        tick();
        check("rst_ready", 64'(if0.cpu_ready), 64'd0);
        check("rst_req",   64'(if0.sdr_req),   64'd0);
        check("rst_busy",  64'(if0.busy),      64'd0);
        check("rst_addr",  64'(if0.sdr_addr),  64'd0);
        check("rst_dout",  64'(if0.cpu_dout),  64'd0);
        reset_n = 1'b1;
        tick();

        // Cold miss
        rd0(20'h00106, 1'b1, 1'b0);
        check("cold_req",   64'(if0.sdr_req),   64'd1);
        check("cold_addr",  64'(if0.sdr_addr),  64'h0000100);
        check("cold_busy",  64'(if0.busy),      64'd1);
        check("cold_noack", 64'(if0.cpu_ready), 64'd0);
        tick();
        check("cold_hold",  64'(if0.sdr_req),   64'd1);
        ack0(64'h4444_3333_2222_1111);
        check("cold_ready", 64'(if0.cpu_ready), 64'd1);
        check("cold_dout",  64'(if0.cpu_dout),  64'h4444);
        check("cold_busy0", 64'(if0.busy),      64'd0);
        check("cold_req0",  64'(if0.sdr_req),   64'd0);
        tick();
        check("cold_pulse", 64'(if0.cpu_ready), 64'd0);

        // Hit in the same line, then a miss on the next line
        rd0(20'h00102, 1'b1, 1'b0);
        check("hit_ready",  64'(if0.cpu_ready), 64'd1);
        check("hit_dout",   64'(if0.cpu_dout),  64'h2222);
        check("hit_noreq",  64'(if0.sdr_req),   64'd0);
        tick();
        rd0(20'h00108, 1'b1, 1'b0);
        check("next_req",   64'(if0.sdr_req),   64'd1);
        check("next_addr",  64'(if0.sdr_addr),  64'h0000108);
        ack0(64'h8888_7777_6666_5555);
        check("next_dout",  64'(if0.cpu_dout),  64'h5555);
        tick();

        // Non-ROM access is left to another block
        rd0(20'he0000, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (if0.cpu_ready !== 1'b0 || if0.sdr_req !== 1'b0) bad++;
            tick();
        end
        check("nonrom_quiet", 64'(bad), 64'd0);

        // Invalidate while the fetch is outstanding
        rd0(20'h00200, 1'b1, 1'b0);
        check("inv_req",    64'(if0.sdr_req),   64'd1);
        if0.invalidate = 1'b1;
        tick();
        if0.invalidate = 1'b0;
        tick();
        ack0(64'hAAAA_BBBB_CCCC_DDDD);
        check("inv_ready",  64'(if0.cpu_ready), 64'd1);
        check("inv_dout",   64'(if0.cpu_dout),  64'hDDDD);
        tick();
        rd0(20'h00200, 1'b1, 1'b0);
        check("inv_remiss", 64'(if0.sdr_req),   64'd1);
        check("inv_rem_rd", 64'(if0.cpu_ready), 64'd0);
        ack0(64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        rd0(20'h00206, 1'b1, 1'b0);
        check("refill_hit", 64'(if0.cpu_ready), 64'd1);
        check("refill_dout",64'(if0.cpu_dout),  64'hAAAA);
        tick();

        // Invalidate coinciding with a would-be hit forces a miss
        rd0(20'h00202, 1'b1, 1'b1);
        check("invhit_req", 64'(if0.sdr_req),   64'd1);
        check("invhit_rdy", 64'(if0.cpu_ready), 64'd0);
        ack0(64'hAAAA_BBBB_CCCC_DDDD);
        check("invhit_dout",64'(if0.cpu_dout),  64'hCCCC);
        tick();

        // Non-zero ROM_BASE, top of the ROM space, long ack delay
        if1.cpu_rd = 1'b1; if1.cpu_rom_memrq = 1'b1; if1.rom_addr = 20'hffff8;
        tick();
        if1.cpu_rd = 1'b0; if1.cpu_rom_memrq = 1'b0;
        check("base_addr",  64'(if1.sdr_addr),  64'h01ffff8);
        check("base_req",   64'(if1.sdr_req),   64'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if1.sdr_req !== 1'b1 || if1.sdr_addr !== 25'h01ffff8) bad++;
        end
        check("base_stable", 64'(bad), 64'd0);
        if1.sdr_ack = 1'b1; if1.sdr_data = 64'h0123_4567_89ab_cdef;
        tick();
        if1.sdr_ack = 1'b0;
        check("base_ready", 64'(if1.cpu_ready), 64'd1);
        check("base_dout",  64'(if1.cpu_dout),  64'hcdef);
        tick();

        // Reset while waiting for the SDRAM
        rd0(20'h00300, 1'b1, 1'b0);
        check("mid_req",    64'(if0.sdr_req),   64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_req0",   64'(if0.sdr_req),   64'd0);
        check("mid_busy0",  64'(if0.busy),      64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        ack0(64'hFFFF_EEEE_DDDD_CCCC);
        check("stray_rdy",  64'(if0.cpu_ready), 64'd0);
        tick();
        check("stray_rdy2", 64'(if0.cpu_ready), 64'd0);
        rd0(20'h00300, 1'b1, 1'b0);
        check("post_miss",  64'(if0.sdr_req),   64'd1);
        check("post_addr",  64'(if0.sdr_addr),  64'h0000300);
        ack0(64'h0000_0000_0000_1234);
        check("post_dout",  64'(if0.cpu_dout),  64'h1234);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
